// File: rtl/mm_operand_loader_if.sv
// Stream-in / operand-out bundle for the 2x2 matrix multiplier loader.
// master drives the element stream and out_ready; slave is the loader.
interface mm_operand_loader_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic [4*WIDTH-1:0] A;
   logic [4*WIDTH-1:0] B;
   logic               out_valid;
   logic               out_ready;
   logic               frame_err;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, A, B, out_valid, frame_err
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, A, B, out_valid, frame_err
   );
endinterface

// File: rtl/mm_operand_loader.sv
// Packs 8 streamed elements into A/B operand words via a ping-pong buffer.
// Optional in_last framing check: define MM_OPERAND_LOADER_FRAME_CHECK_EN.
module mm_operand_loader #(
   parameter int WIDTH = 8
) (
   input logic               clock,
   input logic               reset,
   mm_operand_loader_if.slave bus
);

   logic [WIDTH-1:0] mem [2][8];
   logic [1:0]       full;
   logic             wp;
   logic             rp;
   logic [2:0]       cnt;
   logic             accept;
   logic             drain;
   logic             complete;
   logic             violation;

   assign accept   = bus.in_valid && bus.in_ready;
   assign drain    = bus.out_valid && bus.out_ready;
   assign complete = accept && (cnt == 3'd7) && !violation;

`ifdef MM_OPERAND_LOADER_FRAME_CHECK_EN
   logic err_q;

   // in_last must mark exactly the 8th element of every frame
   assign violation = accept && (bus.in_last != (cnt == 3'd7));

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= violation;
      end
   end

   assign bus.frame_err = err_q;
`else
   logic unused_last;

   assign unused_last   = bus.in_last;
   assign violation     = 1'b0;
   assign bus.frame_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         full <= 2'b00;
         wp   <= 1'b0;
         rp   <= 1'b0;
         cnt  <= 3'd0;
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
               mem[s][i] <= '0;
            end
         end
      end else begin
         if (accept) begin
            mem[wp][cnt] <= bus.in_data;
         end
         if (violation) begin
            cnt <= 3'd0;
         end else if (accept) begin
            cnt <= cnt + 3'd1;
         end
         // fill and drain never address the same slot in one cycle
         if (complete) begin
            full[wp] <= 1'b1;
            wp       <= ~wp;
         end
         if (drain) begin
            full[rp] <= 1'b0;
            rp       <= ~rp;
         end
      end
   end

   assign bus.in_ready  = !full[wp];
   assign bus.out_valid = full[rp];
   assign bus.A = {mem[rp][0], mem[rp][1],
                   mem[rp][2], mem[rp][3]};
   assign bus.B = {mem[rp][4], mem[rp][5],
                   mem[rp][6], mem[rp][7]};

endmodule

// File: tb/tb_mm_operand_loader.sv
// Bench for mm_operand_loader: directed scenarios plus random traffic
// compared every cycle against a frame-queue reference model.
module tb_mm_operand_loader;
   localparam int W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   mm_operand_loader_if #(.WIDTH(W)) bus ();

   mm_operand_loader #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [W-1:0]   part [$];
   logic [8*W-1:0] pend [$];
   bit             exp_err;
   int             n_checks = 0;
   int             n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit lastf();
      return part.size() == 7;
   endfunction

   task automatic check_outputs();
      chk("in_ready", 64'(bus.in_ready), 64'(pend.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(pend.size() > 0));
      if (pend.size() > 0) begin
         chk("A", 64'(bus.A), 64'(pend[0][8*W-1:4*W]));
         chk("B", 64'(bus.B), 64'(pend[0][4*W-1:0]));
      end
      chk("frame_err", 64'(bus.frame_err), 64'(exp_err));
   endtask

   // one clock: drive, predict, advance, then compare
   task automatic cyc(input logic v, input logic [W-1:0] d,
                      input logic lst, input logic ordy,
                      output bit acc);
      bit             drn;
      bit             viol;
      logic [8*W-1:0] f;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = lst;
      bus.out_ready = ordy;
      acc  = v && (pend.size() < 2);
      drn  = ordy && (pend.size() > 0);
      viol = 1'b0;
`ifdef MM_OPERAND_LOADER_FRAME_CHECK_EN
      if (acc) viol = (lst != lastf());
`endif
      @(posedge clock);
      #1;
      if (drn) f = pend.pop_front();
      if (viol) begin
         part.delete();
      end else if (acc) begin
         part.push_back(d);
         if (part.size() == 8) begin
            f = {part[0], part[1], part[2], part[3],
                 part[4], part[5], part[6], part[7]};
            pend.push_back(f);
            part.delete();
         end
      end
      exp_err = viol;
      check_outputs();
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      part.delete();
      pend.delete();
      exp_err = 1'b0;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_A", 64'(bus.A), 64'd0);
      chk("rst_B", 64'(bus.B), 64'd0);
      chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
      reset = 1'b0;
   endtask

   task automatic idle(input int n, input logic ordy);
      bit acc;
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, ordy, acc);
   endtask

   initial begin
      bit acc;
      int k;

      // basic frame
      do_reset();
      idle(1, 1'b1);
      for (int i = 1; i <= 8; i++)
         cyc(1'b1, W'(i), lastf(), 1'b1, acc);
      chk("basic_A", 64'(bus.A), 64'h01020304);
      chk("basic_B", 64'(bus.B), 64'h05060708);
      idle(3, 1'b1);

      // backpressure: 16 accepted while held, then release
      do_reset();
      k = 0;
      for (int i = 0; i < 24; i++) begin
         cyc(1'b1, W'(k + 1), lastf(), 1'b0, acc);
         if (acc) k++;
      end
      chk("held_accepts", 64'(k), 64'd16);
      chk("held_ready", 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < 60 && k < 24; i++) begin
         cyc(1'b1, W'(k + 1), lastf(), 1'b1, acc);
         if (acc) k++;
      end
      chk("release_accepts", 64'(k), 64'd24);
      idle(4, 1'b1);

      // drain of slot 0 coincides with completion of slot 1
      do_reset();
      for (int i = 1; i <= 15; i++)
         cyc(1'b1, W'(8'h20 + i), lastf(), 1'b0, acc);
      cyc(1'b1, 8'h30, lastf(), 1'b1, acc);
      chk("coincide_acc", 64'(acc), 64'd1);
      chk("coincide_A", 64'(bus.A), 64'h292a2b2c);
      chk("coincide_B", 64'(bus.B), 64'h2d2e2f30);
      idle(3, 1'b1);

      // reset mid-frame, then a clean frame
      do_reset();
      for (int i = 1; i <= 5; i++)
         cyc(1'b1, W'(8'h40 + i), lastf(), 1'b0, acc);
      do_reset();
      for (int i = 1; i <= 8; i++)
         cyc(1'b1, W'(8'h10 + i), lastf(), 1'b0, acc);
      chk("post_rst_A", 64'(bus.A), 64'h11121314);
      chk("post_rst_B", 64'(bus.B), 64'h15161718);
      idle(2, 1'b1);

`ifdef MM_OPERAND_LOADER_FRAME_CHECK_EN
      do_reset();
      cyc(1'b1, 8'h51, 1'b0, 1'b1, acc);
      cyc(1'b1, 8'h52, 1'b0, 1'b1, acc);
      cyc(1'b1, 8'h53, 1'b1, 1'b1, acc);
      chk("early_last_err", 64'(bus.frame_err), 64'd1);
      for (int i = 1; i <= 8; i++)
         cyc(1'b1, W'(8'h60 + i), lastf(), 1'b0, acc);
      chk("recover_A", 64'(bus.A), 64'h61626364);
      chk("recover_B", 64'(bus.B), 64'h65666768);
      idle(2, 1'b1);
`endif

      // random gaps and stalls
      do_reset();
      for (int i = 0; i < 800; i++)
         cyc(1'b1 && ($urandom_range(0, 3) != 0), W'($urandom),
             lastf(), $urandom_range(0, 2) != 0, acc);
      idle(20, 1'b1);
      chk("final_empty", 64'(bus.out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
